// File: rtl/encoder_angle_speed_calc_pkg.sv
// Shared project constants for the encoder angle/speed path and the FSM state encoding.
// SAMPLE_CNT_DEF is derived from the sample period and the sys_clk period.
package encoder_angle_speed_calc_pkg;

    localparam int ENC_TOTAL_BITS     = 13;
    localparam int SYS_CLK_PERIOD_NS  = 20;
    localparam int SAMPLE_PERIOD_NS   = 100_000;
    localparam int MOTOR_POLE_PAIRS   = 4;
    localparam int SAMPLE_CNT_DEF     = SAMPLE_PERIOD_NS / SYS_CLK_PERIOD_NS;
    localparam int FRAME_WAIT_CNT_DEF = 800;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_REQUEST = 5'b00010,
        ST_WAIT    = 5'b00100,
        ST_CALC    = 5'b01000,
        ST_OUTPUT  = 5'b10000
    } calc_state_e;

endpackage

// File: rtl/encoder_angle_speed_calc_gray_to_binary.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module encoder_angle_speed_calc_gray_to_binary #(
    parameter int WIDTH = 13
) (
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out
);

    always_comb begin
        bin_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_out[i] = ^(gray_in >> i);
        end
    end

endmodule

// File: rtl/encoder_angle_speed_calc.sv
// Periodic SSI position sampling, electrical angle and per-sample speed computation.
// Define ENCODER_GRAY_DECODE_EN to treat the decoder word as Gray code.
//
// state   | meaning
// IDLE    | waiting for the sample counter to wrap to 0
// REQUEST | one-cycle request pulse to the SSI decoder
// WAIT    | FRAME_WAIT_CNT cycles for the frame to complete
// CALC    | latch position, compute angle and delta
// OUTPUT  | outputs valid, previous position updated
module encoder_angle_speed_calc
    import encoder_angle_speed_calc_pkg::*;
#(
    parameter int POS_WIDTH      = ENC_TOTAL_BITS,
    parameter int POLE_PAIRS     = MOTOR_POLE_PAIRS,
    parameter int SAMPLE_CNT     = SAMPLE_CNT_DEF,
    parameter int FRAME_WAIT_CNT = FRAME_WAIT_CNT_DEF
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 calc_enable_in,
    input  logic [POS_WIDTH-1:0] zero_offset_in,
    input  logic [POS_WIDTH-1:0] location_detection_value_in,
    output logic                 location_detection_enable_out,
    output logic [POS_WIDTH-1:0] elec_angle_out,
    output logic [POS_WIDTH:0]   speed_out,
    output logic                 data_valid_out
);

    localparam int SCW = $clog2(SAMPLE_CNT + 1);
    localparam int WCW = $clog2(FRAME_WAIT_CNT + 1);

    calc_state_e           state_q, state_d;
    logic [SCW-1:0]        sample_cnt_q, sample_cnt_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [POS_WIDTH-1:0]  p_q, p_d;
    logic [POS_WIDTH-1:0]  p_prev_q, p_prev_d;
    logic                  first_q, first_d;
    logic                  req_q, req_d;
    logic [POS_WIDTH-1:0]  angle_q, angle_d;
    logic [POS_WIDTH:0]    speed_q, speed_d;
    logic                  valid_q, valid_d;

    logic [POS_WIDTH-1:0]  pos_dec;
    logic [POS_WIDTH-1:0]  pos_rel;
    logic [POS_WIDTH-1:0]  delta;

`ifdef ENCODER_GRAY_DECODE_EN
    encoder_angle_speed_calc_gray_to_binary #(
        .WIDTH (POS_WIDTH)
    ) u_gray_to_binary (
        .gray_in (location_detection_value_in),
        .bin_out (pos_dec)
    );
`else
    assign pos_dec = location_detection_value_in;
`endif

    // Both differences wrap modulo 2^POS_WIDTH, so a single-turn crossing reads as a small step.
    assign pos_rel = pos_dec - zero_offset_in;
    assign delta   = pos_dec - p_prev_q;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        p_d          = p_q;
        p_prev_d     = p_prev_q;
        first_d      = first_q;
        req_d        = 1'b0;
        angle_d      = angle_q;
        speed_d      = speed_q;
        valid_d      = 1'b0;

        if (!calc_enable_in || sample_cnt_q == SCW'(SAMPLE_CNT - 1)) begin
            sample_cnt_d = '0;
        end else begin
            sample_cnt_d = sample_cnt_q + SCW'(1);
        end

        if (!calc_enable_in) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
            first_d    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sample_cnt_q == '0) begin
                        state_d = ST_REQUEST;
                        req_d   = 1'b1;
                    end
                end
                ST_REQUEST: begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
                ST_WAIT: begin
                    if (wait_cnt_q == WCW'(FRAME_WAIT_CNT - 1)) begin
                        state_d    = ST_CALC;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end
                ST_CALC: begin
                    // Outputs load on entry to OUTPUT so they appear together with data_valid_out.
                    state_d = ST_OUTPUT;
                    p_d     = pos_dec;
                    angle_d = pos_rel * POS_WIDTH'(POLE_PAIRS);
                    speed_d = first_q ? '0 : {delta[POS_WIDTH-1], delta};
                    valid_d = 1'b1;
                end
                ST_OUTPUT: begin
                    state_d  = ST_IDLE;
                    p_prev_d = p_q;
                    first_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            wait_cnt_q   <= '0;
            p_q          <= '0;
            p_prev_q     <= '0;
            first_q      <= 1'b1;
            req_q        <= 1'b0;
            angle_q      <= '0;
            speed_q      <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            p_q          <= p_d;
            p_prev_q     <= p_prev_d;
            first_q      <= first_d;
            req_q        <= req_d;
            angle_q      <= angle_d;
            speed_q      <= speed_d;
            valid_q      <= valid_d;
        end
    end

    assign location_detection_enable_out = req_q;
    assign elec_angle_out                = angle_q;
    assign speed_out                     = speed_q;
    assign data_valid_out                = valid_q;

endmodule

// File: doc/encoder_angle_speed_calc.md
ENCODER_ANGLE_SPEED_CALC -- requirements
Module: encoder_angle_speed_calc

Interface
REQ-001 Parameter POS_WIDTH, default 13: position/angle word width; equals the shared absolute-encoder total-bit constant.
REQ-002 Parameter POLE_PAIRS, default 4: motor pole pairs, integer 1..16.
REQ-003 Parameter SAMPLE_CNT, default 5000: sample period in sys_clk cycles (100 us at 50 MHz).
REQ-004 Parameter FRAME_WAIT_CNT, default 800: cycles allowed for one SSI frame to complete; FRAME_WAIT_CNT+4 < SAMPLE_CNT.
REQ-005 sys_clk  in  1  system clock; all logic on rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 calc_enable_in  in  1  level; high runs periodic sampling.
REQ-008 zero_offset_in  in  POS_WIDTH  mechanical position of electrical zero; sampled in CALC.
REQ-009 location_detection_value_in  in  POS_WIDTH  raw position word from the SSI decoder.
REQ-010 location_detection_enable_out  out  1  one-cycle request pulse to the SSI decoder.
REQ-011 elec_angle_out  out  POS_WIDTH  electrical angle, unsigned, full scale = 360 deg.
REQ-012 speed_out  out  POS_WIDTH+1  signed position delta per sample period.
REQ-013 data_valid_out  out  1  one-cycle pulse when elec_angle_out/speed_out update.

Function
REQ-014 FSM states: IDLE, REQUEST, WAIT, CALC, OUTPUT; one-hot encoded.
REQ-015 Sample counter counts 0..SAMPLE_CNT-1 and wraps while calc_enable_in high; held at 0 otherwise.
REQ-016 IDLE -> REQUEST when calc_enable_in high and sample counter == 0.
REQ-017 REQUEST lasts 1 cycle with location_detection_enable_out high; -> WAIT.
REQ-018 WAIT lasts exactly FRAME_WAIT_CNT cycles (wait counter 0..FRAME_WAIT_CNT-1); -> CALC.
REQ-019 CALC (1 cycle): latch position P = decoded location_detection_value_in; compute D = P - P_prev modulo 2^POS_WIDTH, sign-extended to POS_WIDTH+1; compute A = ((P - zero_offset_in) mod 2^POS_WIDTH) * POLE_PAIRS, truncated to POS_WIDTH bits; -> OUTPUT.
REQ-020 OUTPUT (1 cycle): register A to elec_angle_out, D to speed_out, data_valid_out high, P_prev <= P; -> IDLE.
REQ-021 data_valid_out rises FRAME_WAIT_CNT+2 cycles after the location_detection_enable_out pulse cycle.
REQ-022 First sample after enable rise (first-sample flag set): speed_out = 0, flag cleared at OUTPUT.
REQ-023 Wrap-around: P_prev = 2^POS_WIDTH-2, P = 1 gives D = +3; P_prev = 1, P = 2^POS_WIDTH-2 gives D = -3.
REQ-024 calc_enable_in low in any state: next state IDLE, no pulse issued, outputs hold last values, first-sample flag set.
REQ-025 Illegal FSM encoding returns to IDLE next cycle.

Reset
REQ-026 On reset_n low: FSM IDLE, all counters 0, P_prev 0, first-sample flag set, location_detection_enable_out 0, elec_angle_out 0, speed_out 0, data_valid_out 0.
REQ-027 Reset mid-sequence aborts it; first request follows the first cycle with calc_enable_in high after release.

Configuration
REQ-028 Macro ENCODER_GRAY_DECODE_EN: when defined, CALC converts location_detection_value_in from Gray to binary (b[MSB]=g[MSB], b[i]=b[i+1] xor g[i]) before use; when undefined, the word is used as binary unchanged; latency identical either way.

Structure
REQ-029 Shared project parameter file holds POS_WIDTH default (encoder total bits), sys_clk period, sample period, pole pairs; SAMPLE_CNT derived there as sample period / clock period.
REQ-030 One sub-module natural: gray_to_binary (parameterised width, combinational), instantiated only under ENCODER_GRAY_DECODE_EN.

Verification
REQ-031 SAMPLE_CNT=100, FRAME_WAIT_CNT=20, enable high -> enable_out pulses every 100 cycles; data_valid_out 22 cycles after each pulse.
REQ-032 Binary build, offset 0, POLE_PAIRS 4, position 0x0400 -> elec_angle_out 0x1000; position 0x0900 -> 0x0400 (truncated).
REQ-033 Positions 8190 then 1 (POS_WIDTH 13) -> first valid speed 0, second speed +3; reverse order -> -3.
REQ-034 Gray build, input Gray 0x0003 with offset 0, POLE_PAIRS 1 -> elec_angle_out 0x0002.
REQ-035 Drop calc_enable_in during WAIT -> no data_valid_out, outputs hold; re-enable -> next valid shows speed 0.
REQ-036 Assert reset_n low during CALC -> all outputs 0 next edge; after release with enable high, first pulse at cycle 1.
